// File: rtl/des_ahb_pkg.sv
// Shared constants and types for the Triple-DES AHB-Lite slave front end:
// register map, AHB control encodings, bus FSM states and the address decoder.
package des_ahb_pkg;

    localparam logic [31:0] ADDR_MODE = 32'h0000_0000;
    localparam logic [31:0] ADDR_KEY1 = 32'h0000_0400;
    localparam logic [31:0] ADDR_KEY2 = 32'h0000_0800;
    localparam logic [31:0] ADDR_KEY3 = 32'h0000_0C00;
    localparam logic [31:0] ADDR_INIT = 32'h0000_1000;
    localparam logic [31:0] ADDR_DIN  = 32'hAAAA_AAA4;
    localparam logic [31:0] ADDR_DOUT = 32'hAAAA_AAA8;
    localparam logic [31:0] ADDR_STAT = 32'hAAAA_AAAC;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_8  = 3'b000,
        HSIZE_16 = 3'b001,
        HSIZE_32 = 3'b010,
        HSIZE_64 = 3'b011
    } hsize_t;

    typedef enum logic [2:0] {
        ST_IDLE, ST_WR_DATA, ST_WR_STALL, ST_RD_DATA, ST_RD_STALL, ST_ERR1, ST_ERR2
    } ahb_state_t;

    typedef enum logic [3:0] {
        RG_MODE, RG_KEY1, RG_KEY2, RG_KEY3, RG_INIT, RG_DIN, RG_DOUT, RG_STAT, RG_NONE
    } reg_sel_t;

    function automatic reg_sel_t decode_addr(input logic [31:0] addr);
        reg_sel_t sel;
        case (addr)
            ADDR_MODE: sel = RG_MODE;
            ADDR_KEY1: sel = RG_KEY1;
            ADDR_KEY2: sel = RG_KEY2;
            ADDR_KEY3: sel = RG_KEY3;
            ADDR_INIT: sel = RG_INIT;
            ADDR_DIN:  sel = RG_DIN;
            ADDR_DOUT: sel = RG_DOUT;
            ADDR_STAT: sel = RG_STAT;
            default:   sel = RG_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/ahb_des_slave_if_if.sv
// AHB-Lite bus bundle between the master and the DES slave front end.
interface ahb_des_slave_if_if;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [31:0] HADDR;
    logic [63:0] HWDATA;
    logic [63:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (output HWRITE, HTRANS, HSIZE, HADDR, HWDATA,
                    input  HRDATA, HREADY, HRESP);
    modport slave  (input  HWRITE, HTRANS, HSIZE, HADDR, HWDATA,
                    output HRDATA, HREADY, HRESP);
endinterface

// File: rtl/des_result_fifo.sv
// Synchronous result FIFO with occupancy count; the head word is visible
// combinationally so a pop can be returned in the same bus data phase.
module des_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         srst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         full,
    output logic                         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop frees the head slot, so a simultaneous push is legal even when full.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end
endmodule

// File: rtl/ahb_des_slave_if.sv
// AHB-Lite slave front end for the Triple-DES core: register bank, block
// handoff with backpressure wait states, result FIFO reads and ERROR responses.
module ahb_des_slave_if
    import des_ahb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int RD_TIMEOUT = 16,
    parameter int USE_HTRANS = 0
) (
    input  logic              HCLK,
    input  logic              HRESET,
    ahb_des_slave_if_if.slave bus,
    output logic              enc_dec,
    output logic [63:0]       key1,
    output logic [63:0]       key2,
    output logic [63:0]       key3,
    output logic [63:0]       blk_data,
    output logic              blk_valid,
    input  logic              blk_ready,
    input  logic [63:0]       res_data,
    input  logic              res_valid,
    output logic              res_ready
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(RD_TIMEOUT + 1);

    ahb_state_t    state_q, state_d;
    reg_sel_t      sel_q, sel_d, addr_sel;
    logic          enc_dec_q, enc_dec_d, blk_valid_q, blk_valid_d;
    logic [63:0]   key1_q, key1_d, key2_q, key2_d, key3_q, key3_d;
    logic [63:0]   blk_data_q, blk_data_d;
    logic [TW-1:0] wait_q, wait_d;
    logic          addr_qual, addr_err, busy, hready, hresp, bypass;
    logic [63:0]   hrdata, fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty, fifo_push, fifo_pop;

    // Without HTRANS every address phase is treated as a transfer.
    assign addr_qual = (USE_HTRANS == 0) || (bus.HTRANS == HTRANS_NONSEQ) ||
                       (bus.HTRANS == HTRANS_SEQ);
    assign addr_sel  = decode_addr(bus.HADDR);
    assign addr_err  = (addr_sel == RG_NONE) || (bus.HSIZE != HSIZE_64) ||
                       (bus.HWRITE && (addr_sel == RG_DOUT || addr_sel == RG_STAT)) ||
                       (!bus.HWRITE && addr_sel == RG_DIN);
    assign busy      = blk_valid_q || (state_q != ST_IDLE);

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        enc_dec_d   = enc_dec_q;
        key1_d      = key1_q;
        key2_d      = key2_q;
        key3_d      = key3_q;
        blk_data_d  = blk_data_q;
        blk_valid_d = blk_valid_q && !blk_ready;
        wait_d      = '0;
        hready      = 1'b1;
        hresp       = 1'b0;
        hrdata      = '0;
        fifo_pop    = 1'b0;
        bypass      = 1'b0;
        case (state_q)
            ST_WR_DATA, ST_WR_STALL: begin
                if (sel_q == RG_INIT || sel_q == RG_DIN) begin
                    if (blk_valid_q && !blk_ready) begin
                        hready  = 1'b0;
                        state_d = ST_WR_STALL;
                    end else begin
                        blk_data_d  = bus.HWDATA;
                        blk_valid_d = 1'b1;
                    end
                end else begin
                    case (sel_q)
                        RG_MODE: enc_dec_d = bus.HWDATA[0];
                        RG_KEY1: key1_d    = bus.HWDATA;
                        RG_KEY2: key2_d    = bus.HWDATA;
                        RG_KEY3: key3_d    = bus.HWDATA;
                        default: ;
                    endcase
                end
            end
            ST_RD_DATA, ST_RD_STALL: begin
                case (sel_q)
                    RG_MODE: hrdata = {63'b0, enc_dec_q};
                    RG_KEY1: hrdata = key1_q;
                    RG_KEY2: hrdata = key2_q;
                    RG_KEY3: hrdata = key3_q;
                    RG_INIT: hrdata = blk_data_q;
                    RG_STAT: hrdata = {55'b0, busy, 8'(fifo_count)};
                    RG_DOUT: begin
                        if (!fifo_empty) begin
                            hrdata   = fifo_rdata;
                            fifo_pop = 1'b1;
                        end else if (res_valid && res_ready) begin
                            hrdata = res_data;
                            bypass = 1'b1;
                        end else begin
                            hready = 1'b0;
                            if (wait_q == TW'(RD_TIMEOUT - 1)) begin
                                state_d = ST_ERR1;
                            end else begin
                                wait_d  = wait_q + 1'b1;
                                state_d = ST_RD_STALL;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            ST_ERR1: begin
                hready  = 1'b0;
                hresp   = 1'b1;
                state_d = ST_ERR2;
            end
            ST_ERR2: hresp = 1'b1;
            default: ;
        endcase
        // A completing cycle also samples the next address phase.
        if (hready) begin
            state_d = ST_IDLE;
            if (addr_qual) begin
                sel_d   = addr_sel;
                state_d = addr_err ? ST_ERR1 : (bus.HWRITE ? ST_WR_DATA : ST_RD_DATA);
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            sel_q       <= RG_NONE;
            enc_dec_q   <= 1'b0;
            key1_q      <= '0;
            key2_q      <= '0;
            key3_q      <= '0;
            blk_data_q  <= '0;
            blk_valid_q <= 1'b0;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            enc_dec_q   <= enc_dec_d;
            key1_q      <= key1_d;
            key2_q      <= key2_d;
            key3_q      <= key3_d;
            blk_data_q  <= blk_data_d;
            blk_valid_q <= blk_valid_d;
            wait_q      <= wait_d;
        end
    end

    // A bypassed word goes straight to the bus and is never stored.
    assign fifo_push = res_valid && res_ready && !bypass;

    des_result_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(64)) u_fifo (
        .clk   (HCLK),
        .srst  (HRESET),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (res_data),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.HRDATA = hrdata;
    assign bus.HREADY = hready;
    assign bus.HRESP  = hresp;
    assign enc_dec    = enc_dec_q;
    assign key1       = key1_q;
    assign key2       = key2_q;
    assign key3       = key3_q;
    assign blk_data   = blk_data_q;
    assign blk_valid  = blk_valid_q;
    assign res_ready  = !fifo_full;
endmodule

// File: tb/tb_ahb_des_slave_if.sv
// Directed bench for the DES AHB slave: register setup, block backpressure,
// result FIFO full/wrap/bypass/timeout, ERROR responses and mid-stall reset.
module tb_ahb_des_slave_if;
    import des_ahb_pkg::*;

    localparam logic [63:0] K1 = 64'h6b776c6f70617772;
    localparam logic [63:0] K2 = 64'h64736B65776A7272;
    localparam logic [63:0] K3 = 64'h736865726c6f636b;
    localparam logic [63:0] IV = 64'h14fead4c23fe9280;
    localparam logic [63:0] DI = 64'h8fe0d9c6b3674857;

    logic        HCLK, HRESET;
    logic        enc_dec, blk_valid, blk_ready, res_valid, res_ready;
    logic [63:0] key1, key2, key3, blk_data, res_data;
    int          checks, fails;
    logic [63:0] res_tab [5];

    ahb_des_slave_if_if bus_if();

    ahb_des_slave_if #(.FIFO_DEPTH(4), .RD_TIMEOUT(16), .USE_HTRANS(0)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .bus       (bus_if),
        .enc_dec   (enc_dec),
        .key1      (key1),
        .key2      (key2),
        .key3      (key3),
        .blk_data  (blk_data),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .res_data  (res_data),
        .res_valid (res_valid),
        .res_ready (res_ready)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic park();
        bus_if.HADDR  = ADDR_MODE;
        bus_if.HWRITE = 1'b0;
        bus_if.HSIZE  = 3'b011;
        bus_if.HTRANS = HTRANS_IDLE;
    endtask

    // One AHB transfer; returns wait-state count, ERROR wait states, final HRESP and HRDATA.
    task automatic ahb_xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                            input logic [63:0] wdata, input int push_at, input logic [63:0] push_word,
                            input int rdy_at, output logic [63:0] rdata, output int waits,
                            output int err_waits, output logic resp);
        logic done;
        waits = 0; err_waits = 0; resp = 1'b0; rdata = '0; done = 1'b0;
        @(posedge HCLK); #1;
        bus_if.HADDR = addr; bus_if.HWRITE = wr; bus_if.HSIZE = size; bus_if.HTRANS = HTRANS_NONSEQ;
        @(posedge HCLK); #1;
        park();
        bus_if.HWDATA = wdata;
        for (int k = 0; k < 40; k++) begin
            if (push_at >= 0) begin res_valid = (k == push_at); res_data = push_word; end
            if (rdy_at >= 0) blk_ready = (k >= rdy_at);
            @(negedge HCLK);
            if (bus_if.HREADY === 1'b1) begin
                rdata = bus_if.HRDATA; resp = bus_if.HRESP; done = 1'b1;
                break;
            end
            waits++;
            if (bus_if.HRESP === 1'b1) err_waits++;
            @(posedge HCLK); #1;
        end
        @(posedge HCLK); #1;
        if (push_at >= 0) res_valid = 1'b0;
        $display("xfer %s addr=%h size=%0d wdata=%h rdata=%h waits=%0d err_waits=%0d resp=%0b",
                 wr ? "W" : "R", addr, size, wdata, rdata, waits, err_waits, resp);
        checks++;
        if (!done) begin fails++; $display("FAIL xfer_timeout: addr=%h no HREADY within 40 cycles", addr); end
    endtask

    task automatic test_reset();
        logic [63:0] rd; int w, ew; logic rp;
        HRESET = 1'b1;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        checks++; if (bus_if.HREADY !== 1'b1) begin fails++; $display("FAIL rst_hready: got %b want 1", bus_if.HREADY); end
        checks++; if (bus_if.HRESP !== 1'b0) begin fails++; $display("FAIL rst_hresp: got %b want 0", bus_if.HRESP); end
        checks++; if (bus_if.HRDATA !== 64'h0) begin fails++; $display("FAIL rst_hrdata: got %h want 0", bus_if.HRDATA); end
        checks++; if ({enc_dec, blk_valid} !== 2'b00) begin fails++; $display("FAIL rst_mode_valid: got %b want 00", {enc_dec, blk_valid}); end
        checks++; if ((key1 | key2 | key3) !== 64'h0) begin fails++; $display("FAIL rst_keys: got %h want 0", key1 | key2 | key3); end
        checks++; if (res_ready !== 1'b1) begin fails++; $display("FAIL rst_res_ready: got %b want 1", res_ready); end
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        ahb_xfer(1'b0, ADDR_STAT, 3'b011, 64'h0, -1, 64'h0, -1, rd, w, ew, rp);
        checks++; if (rd !== 64'h100) begin fails++; $display("FAIL rst_status: got %h want %h", rd, 64'h100); end
    endtask

    task automatic test_setup();
        logic [63:0] rd; int w, ew; logic rp;
        ahb_xfer(1'b1, ADDR_MODE, 3'b011, 64'h1, -1, 64'h0, -1, rd, w, ew, rp);
        checks++; if (enc_dec !== 1'b1) begin fails++; $display("FAIL mode_set: got %b want 1", enc_dec); end
        ahb_xfer(1'b1, ADDR_MODE, 3'b011, 64'h0, -1, 64'h0, -1, rd, w, ew, rp);
        checks++; if (enc_dec !== 1'b0) begin fails++; $display("FAIL mode_clr: got %b want 0", enc_dec); end
        ahb_xfer(1'b1, ADDR_KEY1, 3'b011, K1, -1, 64'h0, -1, rd, w, ew, rp);
        ahb_xfer(1'b1, ADDR_KEY2, 3'b011, K2, -1, 64'h0, -1, rd, w, ew, rp);
        ahb_xfer(1'b1, ADDR_KEY3, 3'b011, K3, -1, 64'h0, -1, rd, w, ew, rp);
        checks++; if (key1 !== K1) begin fails++; $display("FAIL key1: got %h want %h", key1, K1); end
        checks++; if (key2 !== K2) begin fails++; $display("FAIL key2: got %h want %h", key2, K2); end
        checks++; if (key3 !== K3) begin fails++; $display("FAIL key3: got %h want %h", key3, K3); end
        ahb_xfer(1'b0, ADDR_KEY2, 3'b011, 64'h0, -1, 64'h0, -1, rd, w, ew, rp);
        checks++; if (rd !== K2) begin fails++; $display("FAIL key2_readback: got %h want %h", rd, K2); end
        ahb_xfer(1'b1, ADDR_INIT, 3'b011, IV, -1, 64'h0, -1, rd, w, ew, rp);
        checks++; if ({blk_valid, blk_data} !== {1'b1, IV}) begin fails++; $display("FAIL init_blk: got %b/%h want 1/%h", blk_valid, blk_data, IV); end
        @(posedge HCLK); #1;
        checks++; if (blk_valid !== 1'b0) begin fails++; $display("FAIL init_pulse: got %b want 0", blk_valid); end
    endtask

    task automatic test_blk_stall();
        logic [63:0] rd; int w, ew; logic rp;
        blk_ready = 1'b0;
        ahb_xfer(1'b1, ADDR_INIT, 3'b011, 64'h1111, -1, 64'h0, -1, rd, w, ew, rp);
        checks++; if (w !== 0) begin fails++; $display("FAIL blk_first_waits: got %0d want 0", w); end
        ahb_xfer(1'b1, ADDR_DIN, 3'b011, DI, -1, 64'h0, 3, rd, w, ew, rp);
        checks++; if (w !== 3) begin fails++; $display("FAIL blk_stall_waits: got %0d want 3", w); end
        checks++; if ({blk_valid, blk_data} !== {1'b1, DI}) begin fails++; $display("FAIL blk_din: got %b/%h want 1/%h", blk_valid, blk_data, DI); end
        @(posedge HCLK); #1;
        checks++; if (blk_valid !== 1'b0) begin fails++; $display("FAIL blk_drop: got %b want 0", blk_valid); end
    endtask

    task automatic test_fifo_full();
        logic [63:0] rd; int w, ew; logic rp;
        for (int i = 0; i < 4; i++) begin
            res_valid = 1'b1; res_data = res_tab[i];
            @(negedge HCLK);
            checks++; if (res_ready !== 1'b1) begin fails++; $display("FAIL fifo_push_rdy%0d: got %b want 1", i, res_ready); end
            @(posedge HCLK); #1;
        end
        res_valid = 1'b0;
        ahb_xfer(1'b0, ADDR_STAT, 3'b011, 64'h0, -1, 64'h0, -1, rd, w, ew, rp);
        checks++; if (rd !== 64'h104) begin fails++; $display("FAIL fifo_stat4: got %h want %h", rd, 64'h104); end
        res_valid = 1'b1; res_data = res_tab[4];
        @(negedge HCLK);
        checks++; if (res_ready !== 1'b0) begin fails++; $display("FAIL fifo_full_rdy: got %b want 0", res_ready); end
        ahb_xfer(1'b0, ADDR_DOUT, 3'b011, 64'h0, -1, 64'h0, -1, rd, w, ew, rp);
        checks++; if ({rp, w[3:0], rd} !== {1'b0, 4'd0, res_tab[0]}) begin fails++; $display("FAIL fifo_pop_first: got %b/%0d/%h want 0/0/%h", rp, w, rd, res_tab[0]); end
        @(negedge HCLK);
        checks++; if (res_ready !== 1'b1) begin fails++; $display("FAIL fifo_fifth_rdy: got %b want 1", res_ready); end
        @(posedge HCLK); #1;
        res_valid = 1'b0;
        ahb_xfer(1'b0, ADDR_STAT, 3'b011, 64'h0, -1, 64'h0, -1, rd, w, ew, rp);
        checks++; if (rd !== 64'h104) begin fails++; $display("FAIL fifo_stat_after: got %h want %h", rd, 64'h104); end
        for (int i = 1; i < 5; i++) begin
            ahb_xfer(1'b0, ADDR_DOUT, 3'b011, 64'h0, -1, 64'h0, -1, rd, w, ew, rp);
            checks++; if (rd !== res_tab[i]) begin fails++; $display("FAIL fifo_drain%0d: got %h want %h", i, rd, res_tab[i]); end
        end
        ahb_xfer(1'b0, ADDR_STAT, 3'b011, 64'h0, -1, 64'h0, -1, rd, w, ew, rp);
        checks++; if (rd !== 64'h100) begin fails++; $display("FAIL fifo_stat_empty: got %h want %h", rd, 64'h100); end
    endtask

    task automatic test_rd_bypass();
        logic [63:0] rd; int w, ew; logic rp;
        ahb_xfer(1'b0, ADDR_DOUT, 3'b011, 64'h0, 5, 64'h5a5a_0000_1234_abcd, -1, rd, w, ew, rp);
        checks++; if (w !== 5) begin fails++; $display("FAIL bypass_waits: got %0d want 5", w); end
        checks++; if ({rp, rd} !== {1'b0, 64'h5a5a_0000_1234_abcd}) begin fails++; $display("FAIL bypass_data: got %b/%h want 0/5a5a00001234abcd", rp, rd); end
        ahb_xfer(1'b0, ADDR_STAT, 3'b011, 64'h0, -1, 64'h0, -1, rd, w, ew, rp);
        checks++; if (rd !== 64'h100) begin fails++; $display("FAIL bypass_not_stored: got %h want %h", rd, 64'h100); end
    endtask

    task automatic test_rd_timeout();
        logic [63:0] rd; int w, ew; logic rp;
        ahb_xfer(1'b0, ADDR_DOUT, 3'b011, 64'h0, -1, 64'h0, -1, rd, w, ew, rp);
        checks++; if (w - ew !== 16) begin fails++; $display("FAIL timeout_okay_waits: got %0d want 16", w - ew); end
        checks++; if ({ew[3:0], rp} !== {4'd1, 1'b1}) begin fails++; $display("FAIL timeout_err: got %0d/%b want 1/1", ew, rp); end
    endtask

    task automatic test_error();
        logic [63:0] rd; int w, ew; logic rp;
        res_valid = 1'b1; res_data = 64'hfeed_beef_0000_0005;
        @(posedge HCLK); #1;
        res_valid = 1'b0;
        ahb_xfer(1'b0, 32'h0000_2000, 3'b011, 64'h0, -1, 64'h0, -1, rd, w, ew, rp);
        checks++; if ({w[3:0], ew[3:0], rp} !== {4'd1, 4'd1, 1'b1}) begin fails++; $display("FAIL err_unmapped: got %0d/%0d/%b want 1/1/1", w, ew, rp); end
        ahb_xfer(1'b1, ADDR_KEY1, 3'b010, 64'hdead, -1, 64'h0, -1, rd, w, ew, rp);
        checks++; if ({w[3:0], ew[3:0], rp} !== {4'd1, 4'd1, 1'b1}) begin fails++; $display("FAIL err_hsize: got %0d/%0d/%b want 1/1/1", w, ew, rp); end
        checks++; if (key1 !== K1) begin fails++; $display("FAIL err_key_kept: got %h want %h", key1, K1); end
        ahb_xfer(1'b1, ADDR_DOUT, 3'b011, 64'h0, -1, 64'h0, -1, rd, w, ew, rp);
        checks++; if ({ew[3:0], rp} !== {4'd1, 1'b1}) begin fails++; $display("FAIL err_wr_ro: got %0d/%b want 1/1", ew, rp); end
        ahb_xfer(1'b0, ADDR_DIN, 3'b011, 64'h0, -1, 64'h0, -1, rd, w, ew, rp);
        checks++; if ({ew[3:0], rp} !== {4'd1, 1'b1}) begin fails++; $display("FAIL err_rd_wo: got %0d/%b want 1/1", ew, rp); end
        ahb_xfer(1'b0, ADDR_STAT, 3'b011, 64'h0, -1, 64'h0, -1, rd, w, ew, rp);
        checks++; if (rd !== 64'h101) begin fails++; $display("FAIL err_fifo_kept: got %h want %h", rd, 64'h101); end
        ahb_xfer(1'b0, ADDR_DOUT, 3'b011, 64'h0, -1, 64'h0, -1, rd, w, ew, rp);
        checks++; if (rd !== 64'hfeed_beef_0000_0005) begin fails++; $display("FAIL err_fifo_word: got %h want feedbeef00000005", rd); end
    endtask

    task automatic test_reset_stall();
        logic [63:0] rd; int w, ew; logic rp;
        // Reset during a result-read stall.
        @(posedge HCLK); #1;
        bus_if.HADDR = ADDR_DOUT; bus_if.HWRITE = 1'b0; bus_if.HTRANS = HTRANS_NONSEQ;
        @(posedge HCLK); #1;
        park();
        @(negedge HCLK);
        checks++; if (bus_if.HREADY !== 1'b0) begin fails++; $display("FAIL rdstall_entered: got %b want 0", bus_if.HREADY); end
        @(posedge HCLK); #1;
        HRESET = 1'b1;
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        @(negedge HCLK);
        checks++; if ({bus_if.HREADY, bus_if.HRESP} !== 2'b10) begin fails++; $display("FAIL rdstall_reset: got %b want 10", {bus_if.HREADY, bus_if.HRESP}); end
        // Reset during a block-write stall with two results queued.
        blk_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge HCLK); #1;
            res_valid = 1'b1; res_data = res_tab[i];
        end
        @(posedge HCLK); #1;
        res_valid = 1'b0;
        ahb_xfer(1'b1, ADDR_INIT, 3'b011, 64'h2222, -1, 64'h0, -1, rd, w, ew, rp);
        bus_if.HADDR = ADDR_DIN; bus_if.HWRITE = 1'b1; bus_if.HTRANS = HTRANS_NONSEQ;
        @(posedge HCLK); #1;
        park();
        bus_if.HWDATA = 64'h3333;
        @(negedge HCLK);
        checks++; if (bus_if.HREADY !== 1'b0) begin fails++; $display("FAIL wrstall_entered: got %b want 0", bus_if.HREADY); end
        @(posedge HCLK); #1;
        HRESET = 1'b1;
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        @(negedge HCLK);
        checks++; if ({bus_if.HREADY, bus_if.HRESP, blk_valid} !== 3'b100) begin fails++; $display("FAIL wrstall_reset: got %b want 100", {bus_if.HREADY, bus_if.HRESP, blk_valid}); end
        checks++; if (key1 !== 64'h0) begin fails++; $display("FAIL wrstall_key_cleared: got %h want 0", key1); end
        blk_ready = 1'b1;
        ahb_xfer(1'b0, ADDR_STAT, 3'b011, 64'h0, -1, 64'h0, -1, rd, w, ew, rp);
        checks++; if (rd !== 64'h100) begin fails++; $display("FAIL wrstall_flushed: got %h want %h", rd, 64'h100); end
    endtask

    initial begin
        checks = 0; fails = 0;
        res_tab[0] = 64'h1000_0000_0000_00a0; res_tab[1] = 64'h2000_0000_0000_00b1;
        res_tab[2] = 64'h3000_0000_0000_00c2; res_tab[3] = 64'h4000_0000_0000_00d3;
        res_tab[4] = 64'h5000_0000_0000_00e4;
        park();
        bus_if.HWDATA = '0;
        blk_ready = 1'b1; res_valid = 1'b0; res_data = '0;
        test_reset();
        test_setup();
        test_blk_stall();
        test_fifo_full();
        test_rd_bypass();
        test_rd_timeout();
        test_error();
        test_reset_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
